// File: rtl/noc_packet_injector_pkg.sv
// Shared NoC types for the tile-side packet injector.
//   xy_t        : mesh coordinate, packed as {y, x}, 3 bits each
//   direction_t : one-hot first-hop field {go_north, go_south, go_west, go_east, go_local}
//   flit_t      : {head, tail, data}
//   k*Lsb       : bit offsets of the head-flit header fields
//   k*Port      : bit index of each direction inside direction_t
package noc;

  localparam int kDataWidth  = 64;
  localparam int kCoordWidth = 3;

  typedef struct packed {
    logic [kCoordWidth-1:0] y;
    logic [kCoordWidth-1:0] x;
  } xy_t;

  typedef struct packed {
    logic go_north;
    logic go_south;
    logic go_west;
    logic go_east;
    logic go_local;
  } direction_t;

  typedef struct packed {
    logic                  head;
    logic                  tail;
    logic [kDataWidth-1:0] data;
  } flit_t;

  localparam int kNorthPort = 4;
  localparam int kSouthPort = 3;
  localparam int kWestPort  = 2;
  localparam int kEastPort  = 1;
  localparam int kLocalPort = 0;

  // Header layout of the head flit; bits above kLenLsb+len width are zero.
  localparam int kRouteLsb   = 0;
  localparam int kDest0Lsb   = 5;
  localparam int kDest1Lsb   = 11;
  localparam int kDestValLsb = 17;
  localparam int kSrcLsb     = 19;
  localparam int kMsgTypeLsb = 25;
  localparam int kLenLsb     = 30;

  // X-first dimension-order hop for a single destination.
  function automatic direction_t first_hop(input xy_t pos, input xy_t dst);
    direction_t d;
    d = '0;
    if (dst.x < pos.x)      d.go_west  = 1'b1;
    else if (dst.x > pos.x) d.go_east  = 1'b1;
    else if (dst.y < pos.y) d.go_north = 1'b1;
    else if (dst.y > pos.y) d.go_south = 1'b1;
    else                    d.go_local = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/noc_first_hop_routing.sv
// Combinational first-hop routing for up to two destinations.
//   position : registered router coordinate
//   dest     : two destination coordinates
//   dest_val : per-destination valid
//   route    : OR of the one-hot hops of all valid destinations
module noc_first_hop_routing
  import noc::*;
(
  input  xy_t        position,
  input  xy_t  [1:0] dest,
  input  logic [1:0] dest_val,
  output direction_t route
);

  direction_t [1:0] hop;

  for (genvar i = 0; i < 2; i++) begin : g_dst
    assign hop[i] = dest_val[i] ? first_hop(position, dest[i]) : direction_t'('0);
  end

  // Identical multicast destinations collapse naturally under the OR.
  assign route = direction_t'(hop[0] | hop[1]);

endmodule

// File: rtl/noc_packet_injector.sv
// Source-side packetizer: turns a (unicast or 2-way multicast) request plus
// a payload stream into a head flit followed by len body flits.
//   clk, rst        : clock, async active-high reset
//   position        : router coordinate, registered before use
//   req_*           : request handshake and fields
//   pay_*           : payload word stream, consumed only while in BODY
//   out_valid/ready : flit handshake toward the router local port
//   out_flit        : {head, tail, data}
//   drop_err        : one-cycle pulse when a request with no valid dest is dropped
module noc_packet_injector
  import noc::*;
#(
  parameter int DataWidth    = 64,
  parameter int LenWidth     = 8,
  parameter int MsgTypeWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  xy_t                     position,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  xy_t  [1:0]              req_dest,
  input  logic [1:0]              req_dest_val,
  input  logic [MsgTypeWidth-1:0] req_msg_type,
  input  logic [LenWidth-1:0]     req_len,
  input  logic                    pay_valid,
  output logic                    pay_ready,
  input  logic [DataWidth-1:0]    pay_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output flit_t                   out_flit,
  output logic                    drop_err
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                  state;
  xy_t                     pos_q;
  xy_t  [1:0]              dest_q;
  logic [1:0]              val_q;
  logic [MsgTypeWidth-1:0] type_q;
  logic [LenWidth-1:0]     len_q;
  logic [LenWidth-1:0]     rem_q;
  direction_t              route_q;
  xy_t                     src_q;

  direction_t              route_c;
  logic [kDataWidth-1:0]   hdr;

  noc_first_hop_routing u_route (
    .position (pos_q),
    .dest     (req_dest),
    .dest_val (req_dest_val),
    .route    (route_c)
  );

  // Gated with rst so no request can be accepted while reset is held.
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos_q    <= '0;
      dest_q   <= '0;
      val_q    <= '0;
      type_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      route_q  <= '0;
      src_q    <= '0;
      drop_err <= 1'b0;
    end else begin
      pos_q    <= position;
      drop_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          dest_q  <= req_dest;
          val_q   <= req_dest_val;
          type_q  <= req_msg_type;
          len_q   <= req_len;
          route_q <= route_c;
          src_q   <= pos_q;
          if (req_dest_val == 2'b00) drop_err <= 1'b1;
          else                       state    <= HEAD;
        end
        HEAD: if (out_ready) begin
          if (len_q == '0) state <= IDLE;
          else begin
            rem_q <= len_q;
            state <= BODY;
          end
        end
        BODY: if (pay_valid && out_ready) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == LenWidth'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hdr = '0;
    hdr[kRouteLsb   +: 5]            = route_q;
    hdr[kDest0Lsb   +: 6]            = dest_q[0];
    hdr[kDest1Lsb   +: 6]            = dest_q[1];
    hdr[kDestValLsb +: 2]            = val_q;
    hdr[kSrcLsb     +: 6]            = src_q;
    hdr[kMsgTypeLsb +: MsgTypeWidth] = type_q;
    hdr[kLenLsb     +: LenWidth]     = len_q;
  end

  // Head flit comes from latched state; body flits are a zero-latency
  // pass-through of the payload handshake.
  always_comb begin
    out_valid = 1'b0;
    pay_ready = 1'b0;
    out_flit  = '0;
    case (state)
      HEAD: begin
        out_valid     = 1'b1;
        out_flit.head = 1'b1;
        out_flit.tail = (len_q == '0);
        out_flit.data = hdr;
      end
      BODY: begin
        out_valid     = pay_valid;
        pay_ready     = out_ready;
        out_flit.tail = (rem_q == LenWidth'(1));
        out_flit.data = pay_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
module tb_noc_packet_injector;
  import noc::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  xy_t         position = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  xy_t  [1:0]  req_dest = '0;
  logic [1:0]  req_dest_val = '0;
  logic [4:0]  req_msg_type = '0;
  logic [7:0]  req_len = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [63:0] pay_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  flit_t       out_flit;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_packet_injector dut (
    .clk(clk), .rst(rst), .position(position),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_dest_val(req_dest_val), .req_msg_type(req_msg_type), .req_len(req_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .drop_err(drop_err)
  );

  // Reference: one direction per valid destination, OR'd; bit order N,S,W,E,L.
  function automatic logic [4:0] ref_route(input xy_t p, input xy_t d0, input xy_t d1,
                                           input logic [1:0] val);
    logic [4:0] r;
    xy_t d;
    int dx, dy;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      if (val[i]) begin
        d  = (i == 0) ? d0 : d1;
        dx = int'(d.x) - int'(p.x);
        dy = int'(d.y) - int'(p.y);
        if (dx < 0)      r[2] = 1'b1;
        else if (dx > 0) r[1] = 1'b1;
        else if (dy < 0) r[4] = 1'b1;
        else if (dy > 0) r[3] = 1'b1;
        else             r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_header(input xy_t p, input xy_t d0, input xy_t d1,
                                             input logic [1:0] val, input logic [4:0] mt,
                                             input logic [7:0] len);
    return {26'd0, len, mt, p.y, p.x, val, d1.y, d1.x, d0.y, d0.x, ref_route(p, d0, d1, val)};
  endfunction

  function automatic xy_t mk(input int x, input int y);
    xy_t v;
    v.x = 3'(x);
    v.y = 3'(y);
    return v;
  endfunction

  // Drives one full packet with optional output stalls / payload gaps and
  // compares every accepted flit against the reference sequence.
  task automatic run_packet(input xy_t p, input xy_t d0, input xy_t d1, input logic [1:0] val,
                            input logic [4:0] mt, input logic [7:0] len,
                            input int stall_pct, input int gap_pct, input string name);
    logic [65:0] exp_q[$];
    logic [65:0] got_q[$];
    logic [63:0] pay[$];
    int pi, budget;
    bit pay_early;
    position = p;
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(len); i++) pay.push_back({$urandom, $urandom});
    exp_q.push_back({1'b1, (len == 8'd0), ref_header(p, d0, d1, val, mt, len)});
    for (int i = 0; i < int'(len); i++) exp_q.push_back({1'b0, (i == int'(len) - 1), pay[i]});
    req_valid = 1'b1; req_dest[0] = d0; req_dest[1] = d1; req_dest_val = val;
    req_msg_type = mt; req_len = len;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready got %b exp 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_dest_val = '0;
    pi = 0; budget = (int'(len) + 1) * 10 + 50; pay_early = 0;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      pay_valid = (pi < int'(len)) && ($urandom_range(99) >= gap_pct);
      pay_data  = (pi < int'(len)) ? pay[pi] : {$urandom, $urandom};
      #1;
      if (pay_ready && got_q.size() == 0) pay_early = 1;
      if (out_valid && out_ready) got_q.push_back(out_flit);
      if (pay_valid && pay_ready) pi++;
      @(negedge clk);
      budget--;
    end
    out_ready = 1'b1; pay_valid = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s flit_count got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s flit%0d got %h exp %h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pay_early || pi != int'(len)) begin
      errors++; $display("FAIL %s payload_consumed got %0d early %0d exp %0d early 0", name, pi, pay_early, len);
    end
    #1;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s idle_after got rdy %b ov %b exp 1 0", name, req_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, out_valid, pay_ready, drop_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {req_ready, out_valid, pay_ready, drop_err});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy %b ov %b exp 1 0", req_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_packet(mk(2,2), mk(0,2), mk(0,0), 2'b01, 5'd3, 8'd0, 0, 0, "unicast_west");
    run_packet(mk(2,2), mk(3,2), mk(2,0), 2'b11, 5'd7, 8'd3, 0, 0, "multicast_en");
    run_packet(mk(1,1), mk(1,1), mk(0,0), 2'b01, 5'd1, 8'd1, 0, 0, "local");
    run_packet(mk(1,1), mk(3,1), mk(3,1), 2'b11, 5'd2, 8'd2, 0, 0, "same_mcast");
    run_packet(mk(4,4), mk(0,0), mk(4,7), 2'b10, 5'd31, 8'd2, 0, 0, "dest1_only_south");
  endtask

  task automatic test_backpressure();
    logic [65:0] held;
    logic [63:0] a, b;
    a = 64'hA5A5_0000_1111_2222; b = 64'h5A5A_3333_4444_5555;
    position = mk(2,2);
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_dest[0] = mk(5,5); req_dest[1] = mk(0,0); req_dest_val = 2'b01;
    req_msg_type = 5'd9; req_len = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    out_ready = 1'b0; pay_valid = 1'b1; pay_data = a;
    #1 held = out_flit;
    checks++;
    if (held !== {2'b10, ref_header(mk(2,2), mk(5,5), mk(0,0), 2'b01, 5'd9, 8'd2)}) begin
      errors++; $display("FAIL bp_head got %h", held);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_flit !== held || pay_ready !== 1'b0) begin
        errors++; $display("FAIL bp_head_hold cyc%0d got %b %h %b exp 1 %h 0", i, out_valid, out_flit, pay_ready, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_flit !== {2'b00, a} || pay_ready !== 1'b0) begin
        errors++; $display("FAIL bp_body_hold cyc%0d got %b %h %b exp 1 %h 0", i, out_valid, out_flit, pay_ready, {2'b00, a});
      end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++;
    if (pay_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release pay_ready got %b exp 1", pay_ready);
    end
    @(negedge clk);
    pay_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_out_valid got %b exp 0", out_valid);
    end
    @(negedge clk);
    pay_valid = 1'b1; pay_data = b; #1;
    checks++;
    if (out_valid !== 1'b1 || out_flit !== {2'b01, b}) begin
      errors++; $display("FAIL bp_tail got %b %h exp 1 %h", out_valid, out_flit, {2'b01, b});
    end
    @(negedge clk);
    pay_valid = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got %b %b exp 1 0", req_ready, out_valid);
    end
  endtask

  task automatic test_drop();
    int ov_seen;
    @(negedge clk);
    req_valid = 1'b1; req_dest[0] = mk(3,3); req_dest_val = 2'b00; req_len = 8'd2;
    pay_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; #1;
    checks++;
    if (drop_err !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL drop_pulse got %b ov %b rdy %b exp 1 0 1", drop_err, out_valid, req_ready);
    end
    ov_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (out_valid || drop_err || pay_ready || !req_ready) ov_seen++;
    end
    checks++;
    if (ov_seen != 0) begin
      errors++; $display("FAIL drop_after got %0d bad cycles exp 0", ov_seen);
    end
    pay_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    position = mk(0,0);
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_dest[0] = mk(1,0); req_dest_val = 2'b01; req_len = 8'd4;
    @(negedge clk);
    req_valid = 1'b0; out_ready = 1'b1; pay_valid = 1'b1; pay_data = 64'h1;
    @(negedge clk);
    @(negedge clk);
    pay_data = 64'h2; #1;
    checks++;
    if (out_valid !== 1'b1 || out_flit.data !== 64'h2) begin
      errors++; $display("FAIL rst_mid_pre got %b %h exp 1 2", out_valid, out_flit.data);
    end
    rst = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || pay_ready !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid got ov %b pr %b rr %b exp 0 0 0", out_valid, pay_ready, req_ready);
    end
    @(negedge clk);
    rst = 1'b0; pay_valid = 1'b0;
    run_packet(mk(3,3), mk(3,0), mk(6,3), 2'b11, 5'd4, 8'd1, 0, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_packet(mk($urandom_range(7), $urandom_range(7)), mk($urandom_range(7), $urandom_range(7)),
                 mk($urandom_range(7), $urandom_range(7)), 2'($urandom_range(1, 3)),
                 5'($urandom), 8'($urandom_range(0, 6)), 30, 30, "random");
  endtask

  task automatic test_long();
    run_packet(mk(5,2), mk(5,2), mk(1,6), 2'b11, 5'd17, 8'd255, 10, 10, "len255");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_drop();
    test_rst_mid();
    test_random();
    test_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Source-side packetizer at a tile's local router input port.
- Accepts a unicast or 2-way multicast message request plus a stream of payload words, and emits a head flit followed by body flits into the mesh.
- Computes the first-hop one-hot routing field carried in the head flit. Downstream routers compute each subsequent hop from it via lookahead.
- Routing policy is deterministic X-first (west/east), then Y (north/south), matching the mesh's lookahead routing.

Parameters:
- DataWidth, 64, flit payload width; flit width is DataWidth+2 (head and tail bits).
- LenWidth, 8, width of the body-flit count field.
- MsgTypeWidth, 5, message type field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- position  in  noc::xy_t  static router x,y coordinates; registered internally, so it takes effect one cycle later
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_dest  in  noc::xy_t [1:0]  destination coordinates
- req_dest_val  in  2  per-destination valid
- req_msg_type  in  MsgTypeWidth  message type
- req_len  in  LenWidth  number of body flits (0 = head-only packet)
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word consumed
- pay_data  in  DataWidth  payload word
- out_valid  out  1  flit valid toward the router local port
- out_ready  in  1  router local port can accept a flit
- out_flit  out  noc::flit_t  {head, tail, data}
- drop_err  out  1  one-cycle pulse when a request with req_dest_val==0 is dropped

Behaviour:
- Reset (async): state IDLE; req_ready=0 while rst is asserted; out_valid=0, pay_ready=0, drop_err=0; all latched fields cleared.
- FSM states: IDLE, HEAD, BODY.
- IDLE
  - req_ready=1.
  - On handshake, latch dest, dest_val, msg_type and len, and compute the routing field.
  - If dest_val==0: pulse drop_err next cycle and stay in IDLE; no flits are emitted.
  - Otherwise go to HEAD. Latency from request handshake to out_valid is 1 cycle.
- HEAD
  - out_valid=1; head=1; tail=(len==0).
  - Header data layout, all other bits 0:
    - [4:0] routing {go_north, go_south, go_west, go_east, go_local} per noc::direction_t
    - [10:5] dest0 {y[2:0], x[2:0]}
    - [16:11] dest1 {y, x}
    - [18:17] dest_val
    - [24:19] source position {y, x}
    - [29:25] msg_type
    - [37:30] len
  - On out_ready: if len==0 go to IDLE, else load remaining=len and go to BODY.
  - out_flit holds stable while out_valid & !out_ready.
- BODY
  - Zero-latency pass-through: out_valid=pay_valid; pay_ready=out_ready; data=pay_data; head=0; tail=(remaining==1).
  - On out_valid & out_ready, decrement remaining. When it hits 0, go to IDLE.
  - req_ready=0 in HEAD and BODY. Back-to-back packets cost one IDLE cycle.
- Routing, per destination i with dest_val[i]=1, using the registered position P:
  - D.x<P.x -> go_west; D.x>P.x -> go_east.
  - Else D.y<P.y -> go_north; D.y>P.y -> go_south.
  - Else go_local.
  - Field = bitwise OR over valid destinations. Comparisons are unsigned 3-bit.
- Boundaries:
  - Identical multicast destinations produce a single direction.
  - A destination equal to P produces go_local.
  - Assertion of rst mid-packet abandons the packet immediately; the router must be reset concurrently.
  - pay_valid asserted outside BODY is ignored (pay_ready=0).
  - len=255 emits 256 flits.

Decomposition:
- Package noc: xy_t (x, y, 3 bits each), direction_t, flit_t, header field offset constants, and kNorthPort/kSouthPort/kWestPort/kEastPort/kLocalPort.
- Sub-module noc_first_hop_routing: combinational position/dest/val -> direction_t.
- FSM, counter and header packing live in the top module.

Test Plan:
- P=(2,2), unicast dest0=(0,2), len=0 -> one flit, head=tail=1, routing=go_west, data[18:17]=01.
- P=(2,2), multicast dest0=(3,2), dest1=(2,0), len=3, payloads A,B,C -> routing=go_east|go_north; 4 flits; tail only on C.
- P=(1,1), dest0=(1,1) -> routing=go_local.
- Hold out_ready=0 for 5 cycles in HEAD and BODY -> out_flit stable and no payload consumed; pay_valid gaps -> out_valid gaps, order preserved.
- req_dest_val=00 -> no out_valid, drop_err pulses once, req_ready remains 1.
- Assert rst during the 2nd body flit of len=4 -> out_valid=0 immediately; the next request after deassertion produces a correct head flit.
